lsu_memex: RTL and testbench

- Load/store unit of the MEMEX stage.
- Consumes the access fields latched by the MEMPREP→MEMEX pipeline register: address, store data, width, sign-extend and write-enable.
- Acts as initiator on the core's data bus (req/gnt address phase, rvalid response phase).
- Stalls the pipeline until the access completes, then presents aligned, extended load data to the writeback mux.

---
 rtl/topaz_pkg.sv | 38 +++
 rtl/lsu_align.sv | 33 +++
 rtl/lsu_memex.sv | 167 ++++++++++++++++
 tb/tb_lsu_memex.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/topaz_pkg.sv
// Shared types and helpers for the topaz core's MEMEX load/store path.
package topaz_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } data_width_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Reserved width 2'b11 falls through to the word cases.
    function automatic logic [3:0] byte_enable(input logic [1:0] width, input logic [1:0] offset);
        case (width)
            BYTE:    byte_enable = BE_BYTE << offset;
            HALF:    byte_enable = BE_HALF << offset;
            default: byte_enable = BE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
        case (width)
            BYTE:    is_misaligned = 1'b0;
            HALF:    is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane formatting: store data replication or load lane extract with zero/sign extension.
module lsu_align
    import topaz_pkg::*;
(
    input  logic        store_i,
    input  logic [1:0]  width_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = data_i >> {offset_i, 3'b000};
        data_o  = data_i;
        if (store_i) begin
            case (width_i)
                BYTE:    data_o = {4{data_i[7:0]}};
                HALF:    data_o = {2{data_i[15:0]}};
                default: data_o = data_i;
            endcase
        end else begin
            case (width_i)
                BYTE:    data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
                HALF:    data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/lsu_memex.sv
// MEMEX load/store unit: drives the req/gnt/rvalid data bus, stalls the pipeline
// until the access completes and returns formatted load data.
module lsu_memex
    import topaz_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        invalid_MEMEX,
    input  logic        stalled_MEMEX,
    input  logic        lsu_re_MEMEX,
    input  logic        lsu_we_MEMEX,
    input  logic [31:0] alu_result_MEMEX,
    input  logic [31:0] rs2_data_MEMEX,
    input  logic [1:0]  data_width_MEMEX,
    input  logic        lsu_sign_extend_MEMEX,
    output logic        lsu_stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_fault,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  width_q, width_d;
    logic        we_q, we_d;
    logic        sext_q, sext_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;

    logic        acc;
    logic        misaligned;
    logic        issue;
    logic        timeout;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign acc        = (lsu_re_MEMEX | lsu_we_MEMEX) & ~invalid_MEMEX & ~stalled_MEMEX;
    assign misaligned = is_misaligned(data_width_MEMEX, alu_result_MEMEX[1:0]);
    assign issue      = (state_q == IDLE) & acc & ~misaligned;
    assign timeout    = (cnt_q >= 16'(TIMEOUT_CYCLES - 1));

    lsu_align u_store_align (
        .store_i    (1'b1),
        .width_i    (data_width_MEMEX),
        .sign_ext_i (1'b0),
        .offset_i   (alu_result_MEMEX[1:0]),
        .data_i     (rs2_data_MEMEX),
        .data_o     (st_wdata)
    );

    lsu_align u_load_align (
        .store_i    (1'b0),
        .width_i    (width_q),
        .sign_ext_i (sext_q),
        .offset_i   (addr_q[1:0]),
        .data_i     (dbus_rdata),
        .data_o     (ld_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        width_d = width_q;
        we_d    = we_q;
        sext_d  = sext_q;
        fault_d = 1'b0;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        addr_d  = alu_result_MEMEX;
                        wdata_d = st_wdata;
                        be_d    = byte_enable(data_width_MEMEX, alu_result_MEMEX[1:0]);
                        width_d = data_width_MEMEX;
                        we_d    = lsu_we_MEMEX;
                        sext_d  = lsu_sign_extend_MEMEX;
                        state_d = dbus_gnt ? DATA : ADDR;
                    end
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 16'd1;
                if (dbus_gnt) begin
                    state_d = DATA;
                end else if (timeout) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 16'd1;
                // A completing response wins over a timeout expiring in the same cycle.
                if (dbus_rvalid) begin
                    state_d = DONE;
                    fault_d = dbus_err;
                    if (!dbus_err && !we_q) begin
                        rdata_d = ld_data;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            width_q <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            width_q <= width_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first request cycle comes straight from the pipeline fields; later ones from the latched copies.
    always_comb begin
        dbus_req   = issue | (state_q == ADDR);
        dbus_we    = issue ? lsu_we_MEMEX : we_q;
        dbus_addr  = issue ? {alu_result_MEMEX[31:2], 2'b00} : {addr_q[31:2], 2'b00};
        dbus_be    = issue ? byte_enable(data_width_MEMEX, alu_result_MEMEX[1:0]) : be_q;
        dbus_wdata = issue ? st_wdata : wdata_q;
        lsu_stall  = ((state_q == IDLE) & acc) | (state_q == ADDR) | (state_q == DATA);
        lsu_fault  = fault_q;
        lsu_rdata  = rdata_q;
    end

endmodule

// File: tb/tb_lsu_memex.sv
// Self-checking bench for lsu_memex: scripted bus responses, queue scoreboard of completion results.
module tb_lsu_memex;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        invalid_MEMEX;
   logic        stalled_MEMEX;
   logic        lsu_re_MEMEX;
   logic        lsu_we_MEMEX;
   logic [31:0] alu_result_MEMEX;
   logic [31:0] rs2_data_MEMEX;
   logic [1:0]  data_width_MEMEX;
   logic        lsu_sign_extend_MEMEX;
   logic        lsu_stall;
   logic [31:0] lsu_rdata;
   logic        lsu_fault;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_gnt;
   logic        dbus_rvalid;
   logic [31:0] dbus_rdata;
   logic        dbus_err;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          stallCycles;
   } expect_t;

   expect_t scoreboard[$];
   int checkCount = 0;
   int errorCount = 0;

   lsu_memex #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .invalid_MEMEX         (invalid_MEMEX),
      .stalled_MEMEX         (stalled_MEMEX),
      .lsu_re_MEMEX          (lsu_re_MEMEX),
      .lsu_we_MEMEX          (lsu_we_MEMEX),
      .alu_result_MEMEX      (alu_result_MEMEX),
      .rs2_data_MEMEX        (rs2_data_MEMEX),
      .data_width_MEMEX      (data_width_MEMEX),
      .lsu_sign_extend_MEMEX (lsu_sign_extend_MEMEX),
      .lsu_stall             (lsu_stall),
      .lsu_rdata             (lsu_rdata),
      .lsu_fault             (lsu_fault),
      .dbus_req              (dbus_req),
      .dbus_we               (dbus_we),
      .dbus_addr             (dbus_addr),
      .dbus_be               (dbus_be),
      .dbus_wdata            (dbus_wdata),
      .dbus_gnt              (dbus_gnt),
      .dbus_rvalid           (dbus_rvalid),
      .dbus_rdata            (dbus_rdata),
      .dbus_err              (dbus_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drives one MEMEX access and a scripted bus response, then compares the completion against the scoreboard.
   // gntDelay < 0 means no bus request is expected; rvDelay < 0 means the bus never responds.
   task automatic applyStimulus(input string tag, input logic re, input logic we,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [1:0] width, input logic sext,
                                input int gntDelay, input int rvDelay,
                                input logic [31:0] busData, input logic busErr,
                                input logic [3:0] expBe, input logic [31:0] expWdata,
                                input logic [31:0] expRdata, input logic expFault,
                                input int expStall);
      expect_t e;
      int      stallSeen;
      bit      finished;
      e.rdata       = expRdata;
      e.fault       = expFault;
      e.stallCycles = expStall;
      scoreboard.push_back(e);
      stallSeen = 0;
      finished  = 1'b0;
      lsu_re_MEMEX          = re;
      lsu_we_MEMEX          = we;
      alu_result_MEMEX      = addr;
      rs2_data_MEMEX        = rs2;
      data_width_MEMEX      = width;
      lsu_sign_extend_MEMEX = sext;
      for (int c = 0; c < 40 && !finished; c++) begin
         dbus_gnt    = (gntDelay >= 0) && (c == gntDelay);
         dbus_rvalid = (gntDelay >= 0) && (rvDelay > 0) && (c == gntDelay + rvDelay);
         dbus_rdata  = dbus_rvalid ? busData : 32'h5A5A_5A5A;
         dbus_err    = dbus_rvalid ? busErr : 1'b0;
         @(negedge clk);
         checkOutput({tag, ".req"}, {31'd0, dbus_req}, {31'd0, (gntDelay >= 0) && (c <= gntDelay)});
         if (dbus_req) begin
            checkOutput({tag, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
            checkOutput({tag, ".be"}, {28'd0, dbus_be}, {28'd0, expBe});
            checkOutput({tag, ".we"}, {31'd0, dbus_we}, {31'd0, we});
            if (we) checkOutput({tag, ".wdata"}, dbus_wdata, expWdata);
         end
         if (lsu_stall) begin
            stallSeen++;
            checkOutput({tag, ".faultEarly"}, {31'd0, lsu_fault}, 32'd0);
         end else begin
            e = scoreboard.pop_front();
            finished = 1'b1;
            checkOutput({tag, ".stallCycles"}, stallSeen, e.stallCycles);
            checkOutput({tag, ".rdata"}, lsu_rdata, e.rdata);
            checkOutput({tag, ".fault"}, {31'd0, lsu_fault}, {31'd0, e.fault});
         end
         @(posedge clk);
         #1;
      end
      if (!finished) begin
         void'(scoreboard.pop_front());
         checkOutput({tag, ".completionTimeout"}, 32'd0, 32'd1);
      end
      lsu_re_MEMEX = 1'b0;
      lsu_we_MEMEX = 1'b0;
      dbus_gnt     = 1'b0;
      dbus_rvalid  = 1'b0;
      dbus_err     = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".faultCleared"}, {31'd0, lsu_fault}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n                 = 1'b0;
      invalid_MEMEX         = 1'b0;
      stalled_MEMEX         = 1'b0;
      lsu_re_MEMEX          = 1'b0;
      lsu_we_MEMEX          = 1'b0;
      alu_result_MEMEX      = '0;
      rs2_data_MEMEX        = '0;
      data_width_MEMEX      = 2'b00;
      lsu_sign_extend_MEMEX = 1'b0;
      dbus_gnt              = 1'b0;
      dbus_rvalid           = 1'b0;
      dbus_rdata            = '0;
      dbus_err              = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset.req", {31'd0, dbus_req}, 32'd0);
      checkOutput("reset.stall", {31'd0, lsu_stall}, 32'd0);
      checkOutput("reset.fault", {31'd0, lsu_fault}, 32'd0);
      checkOutput("reset.rdata", lsu_rdata, 32'd0);
      checkOutput("reset.addr", dbus_addr, 32'd0);
      @(posedge clk);
      #1;

      applyStimulus("lwZeroWait", 1, 0, 32'h100, 32'h0, 2'b10, 0, 0, 1, 32'hDEAD_BEEF, 0,
                    4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 2);
      applyStimulus("lbSigned", 1, 0, 32'h103, 32'h0, 2'b00, 1, 0, 1, 32'h80FF_0000, 0,
                    4'b1000, 32'h0, 32'hFFFF_FF80, 0, 2);
      applyStimulus("lbUnsigned", 1, 0, 32'h103, 32'h0, 2'b00, 0, 0, 1, 32'h80FF_0000, 0,
                    4'b1000, 32'h0, 32'h0000_0080, 0, 2);
      applyStimulus("shGntDelay", 0, 1, 32'h102, 32'h1234_ABCD, 2'b01, 0, 3, 1, 32'hFFFF_FFFF, 0,
                    4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 0, 5);
      applyStimulus("lwMisaligned", 1, 0, 32'h101, 32'h0, 2'b10, 0, -1, -1, 32'h0, 0,
                    4'b1111, 32'h0, 32'h0000_0080, 1, 1);
      applyStimulus("lhSigned", 1, 0, 32'h102, 32'h0, 2'b01, 1, 1, 2, 32'h8001_0000, 0,
                    4'b1100, 32'h0, 32'hFFFF_8001, 0, 4);
      applyStimulus("lwBusErr", 1, 0, 32'h200, 32'h0, 2'b10, 0, 0, 1, 32'h1234_5678, 1,
                    4'b1111, 32'h0, 32'hFFFF_8001, 1, 2);
      applyStimulus("lwTimeout", 1, 0, 32'h200, 32'h0, 2'b10, 0, 0, -1, 32'h0, 0,
                    4'b1111, 32'h0, 32'hFFFF_8001, 1, TMO + 1);

      // A late response after the timeout must not disturb anything.
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h7777_7777;
      @(negedge clk);
      checkOutput("strayRvalid.stall", {31'd0, lsu_stall}, 32'd0);
      @(posedge clk);
      #1;
      dbus_rvalid = 1'b0;
      @(negedge clk);
      checkOutput("strayRvalid.rdata", lsu_rdata, 32'hFFFF_8001);
      checkOutput("strayRvalid.fault", {31'd0, lsu_fault}, 32'd0);
      @(posedge clk);
      #1;

      applyStimulus("sbLane1", 0, 1, 32'h001, 32'h0000_00A5, 2'b00, 0, 0, 1, 32'h0, 0,
                    4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001, 0, 2);
      applyStimulus("lwReserved", 1, 0, 32'h104, 32'h0, 2'b11, 1, 0, 1, 32'h8BAD_F00D, 0,
                    4'b1111, 32'h0, 32'h8BAD_F00D, 0, 2);
      applyStimulus("lhUnsigned", 1, 0, 32'h100, 32'h0, 2'b01, 0, 0, 1, 32'h1234_F00D, 0,
                    4'b0011, 32'h0, 32'h0000_F00D, 0, 2);

      // Bubbles never reach the bus.
      lsu_re_MEMEX     = 1'b1;
      alu_result_MEMEX = 32'h100;
      data_width_MEMEX = 2'b10;
      invalid_MEMEX    = 1'b1;
      @(negedge clk);
      checkOutput("bubbleInvalid.req", {31'd0, dbus_req}, 32'd0);
      checkOutput("bubbleInvalid.stall", {31'd0, lsu_stall}, 32'd0);
      @(posedge clk);
      #1;
      invalid_MEMEX = 1'b0;
      stalled_MEMEX = 1'b1;
      @(negedge clk);
      checkOutput("bubbleStalled.req", {31'd0, dbus_req}, 32'd0);
      checkOutput("bubbleStalled.stall", {31'd0, lsu_stall}, 32'd0);
      @(posedge clk);
      #1;
      stalled_MEMEX = 1'b0;
      lsu_re_MEMEX  = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of the response phase abandons the access.
      lsu_re_MEMEX     = 1'b1;
      alu_result_MEMEX = 32'h300;
      data_width_MEMEX = 2'b10;
      dbus_gnt         = 1'b1;
      @(posedge clk);
      #1;
      dbus_gnt = 1'b0;
      @(negedge clk);
      checkOutput("resetDuringData.stallBefore", {31'd0, lsu_stall}, 32'd1);
      #1;
      rst_n        = 1'b0;
      lsu_re_MEMEX = 1'b0;
      #1;
      checkOutput("resetDuringData.req", {31'd0, dbus_req}, 32'd0);
      checkOutput("resetDuringData.stall", {31'd0, lsu_stall}, 32'd0);
      checkOutput("resetDuringData.rdata", lsu_rdata, 32'd0);
      checkOutput("resetDuringData.fault", {31'd0, lsu_fault}, 32'd0);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      dbus_rvalid = 1'b0;
      @(negedge clk);
      checkOutput("resetDuringData.afterRdata", lsu_rdata, 32'd0);
      checkOutput("resetDuringData.afterStall", {31'd0, lsu_stall}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
